// File: rtl/picosoc_mem_arb_if.sv
// rtl/picosoc_mem_arb_if.sv - two-master / one-slave memory bus bundle for picosoc_mem_arb
interface picosoc_mem_arb_if;
   logic        m0_valid;
   logic        m0_ready;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic [3:0]  m0_wstrb;
   logic [31:0] m0_rdata;

   logic        m1_valid;
   logic        m1_ready;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_wstrb;
   logic [31:0] m1_rdata;

   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata;

   logic        grant;
   logic        timeout_err;

   // Arbiter side: serves both CPU masters and drives the shared slave bus
   modport master (
      input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
      output m1_ready, m1_rdata,
      output s_valid, s_addr, s_wdata, s_wstrb,
      input  s_ready, s_rdata,
      output grant, timeout_err
   );

   // Environment side: the two masters and the memory slave
   modport slave (
      output m0_valid, m0_addr, m0_wdata, m0_wstrb,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_addr, m1_wdata, m1_wstrb,
      input  m1_ready, m1_rdata,
      input  s_valid, s_addr, s_wdata, s_wstrb,
      output s_ready, s_rdata,
      input  grant, timeout_err
   );
endinterface

// File: rtl/picosoc_mem_arb.sv
// rtl/picosoc_mem_arb.sv - round-robin two-master memory arbiter; PICOSOC_MEMARB_TIMEOUT_EN adds a forced-completion watchdog
module picosoc_mem_arb #(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               reset,
   picosoc_mem_arb_if.master bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   last_grant_q, last_grant_d;
   logic   win;
   logic   fire;
   logic   done;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("picosoc_mem_arb: TIMEOUT must be 1..255");
   end

   // Tie goes to the master that did not own the bus last; a lone requester simply wins
   assign win  = (bus.m0_valid && bus.m1_valid) ? ~last_grant_q : bus.m1_valid;
   assign done = (state_q == BUSY) && (bus.s_ready || fire);

`ifdef PICOSOC_MEMARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
   logic [7:0] cnt_q, cnt_d;

   // Counter sits at zero while idle, so each transaction starts counting from zero
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY && !bus.s_ready) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A slave response in the expiry cycle wins over the forced completion
   assign fire = (state_q == BUSY) && !bus.s_ready && ((cnt_q + 8'd1) == TIMEOUT_CNT);
`else
   assign fire = 1'b0;
`endif

   // State, grant and round-robin history registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state: arbitrate in IDLE, wait for completion in BUSY
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (bus.m0_valid || bus.m1_valid) begin
               state_d = BUSY;
               grant_d = win;
            end
         end
         BUSY: begin
            if (done) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
      endcase
   end

   // Outputs: route the granted master to the slave and return data only to it
   always_comb begin
      logic [31:0] rdata_sel;
      bus.s_valid     = 1'b0;
      bus.s_addr      = '0;
      bus.s_wdata     = '0;
      bus.s_wstrb     = '0;
      bus.m0_ready    = 1'b0;
      bus.m0_rdata    = '0;
      bus.m1_ready    = 1'b0;
      bus.m1_rdata    = '0;
      bus.timeout_err = 1'b0;
      rdata_sel       = fire ? 32'hDEAD_BEEF : bus.s_rdata;
      if (state_q == BUSY) begin
         bus.s_valid = !fire;
         bus.s_addr  = grant_q ? bus.m1_addr  : bus.m0_addr;
         bus.s_wdata = grant_q ? bus.m1_wdata : bus.m0_wdata;
         bus.s_wstrb = grant_q ? bus.m1_wstrb : bus.m0_wstrb;
      end
      // Reset in the completion cycle aborts the transfer without a ready pulse
      if (done && !reset) begin
         bus.timeout_err = fire;
         if (grant_q) begin
            bus.m1_ready = 1'b1;
            bus.m1_rdata = rdata_sel;
         end else begin
            bus.m0_ready = 1'b1;
            bus.m0_rdata = rdata_sel;
         end
      end
   end

   assign bus.grant = grant_q;
endmodule

// File: doc/picosoc_mem_arb.md
PICOSOC_MEM_ARB -- requirements
Module: picosoc_mem_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the number of BUSY cycles without s_ready before a forced completion (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have ports m0_valid/m1_valid, input, 1, the master request.
REQ-005 The block SHALL have ports m0_ready/m1_ready, output, 1, the master completion strobe.
REQ-006 The block SHALL have ports m0_addr/m1_addr and m0_wdata/m1_wdata, input, 32, the master address and write data.
REQ-007 The block SHALL have ports m0_wstrb/m1_wstrb, input, 4, the byte write strobes; 0 means read.
REQ-008 The block SHALL have ports m0_rdata/m1_rdata, output, 32, the master read data.
REQ-009 The block SHALL have ports s_valid (output, 1), s_ready (input, 1), s_addr (output, 32), s_wdata (output, 32), s_wstrb (output, 4) and s_rdata (input, 32), forming the shared slave bus.
REQ-010 The block SHALL have port grant, output, 1, the index of the master currently owning the bus; it is valid while s_valid=1.
REQ-011 The block SHALL have port timeout_err, output, 1, a one-cycle pulse on forced completion.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, held in a registered state variable.
REQ-013 In IDLE with any mN_valid=1, the block SHALL register the winner into grant and go to BUSY on the next edge.
REQ-014 Arbitration SHALL be round-robin: with both requesting, the master not granted most recently wins; with one requesting, that master wins.
REQ-015 In BUSY, s_valid SHALL be 1, and s_addr/s_wdata/s_wstrb SHALL combinationally equal the granted master's inputs.
REQ-016 In IDLE, s_valid, s_addr, s_wdata and s_wstrb SHALL be 0.
REQ-017 In BUSY with s_ready=1, the block SHALL drive m[grant]_ready=1 in that same cycle, with m[grant]_rdata=s_rdata.
REQ-018 On the cycle of REQ-017, the block SHALL record last_grant=grant and return to IDLE.
REQ-019 The non-granted master's ready SHALL be 0 at all times, and its rdata SHALL be 0.
REQ-020 Latency SHALL be 1 arbitration cycle plus slave latency; back-to-back transactions SHALL have at least one IDLE cycle between them.
REQ-021 A master deasserting valid while granted is a protocol violation; the transaction SHALL still run to completion.
REQ-022 A valid arriving in the same cycle as another master's ready SHALL wait for IDLE and SHALL then be arbitrated normally.
REQ-023 s_ready seen in IDLE SHALL be ignored.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL force state=IDLE, grant=0, last_grant=1 (m0 wins the first tie), timeout counter=0 and timeout_err=0.
REQ-025 Reset asserted during BUSY SHALL abort the transaction with no ready pulse to any master.

Configuration
REQ-026 With macro PICOSOC_MEMARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-027 With PICOSOC_MEMARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL, in that cycle, assert m[grant]_ready with m[grant]_rdata=32'hDEAD_BEEF.
REQ-028 On the forced completion of REQ-027, the block SHALL pulse timeout_err=1, drive s_valid=0, and return to IDLE.
REQ-029 With PICOSOC_MEMARB_TIMEOUT_EN defined, s_ready=1 in the same cycle the counter reaches TIMEOUT SHALL take priority as a normal completion with no error.
REQ-030 Without PICOSOC_MEMARB_TIMEOUT_EN, the block SHALL contain no counter, timeout_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-031 The bench SHALL cover: m0 read of addr 0x10, slave ready 2 cycles after s_valid with s_rdata=0x12345678 -> m0_ready pulses once with m0_rdata=0x12345678, and m1_ready stays 0.
REQ-032 The bench SHALL cover: both masters request from reset -> m0 is granted first, then m1; with both held requesting, the sequence alternates 0,1,0,1.
REQ-033 The bench SHALL cover: m1 write, wstrb=4'b0011, wdata=0xAABBCCDD, addr 0x200 -> s_wstrb=0011, s_wdata=0xAABBCCDD and s_addr=0x200 while s_valid=1.
REQ-034 The bench SHALL cover: reset pulsed during a BUSY m0 transaction -> s_valid=0 next cycle, no mN_ready pulse, and the next tie goes to m0.
REQ-035 The bench SHALL cover, with PICOSOC_MEMARB_TIMEOUT_EN and TIMEOUT=4, a slave that never responds -> after 4 BUSY cycles m0_ready=1 with m0_rdata=0xDEADBEEF and timeout_err=1 for one cycle.
REQ-036 The bench SHALL cover, with TIMEOUT=4, s_ready arriving exactly on the 4th BUSY cycle -> normal data is returned and timeout_err stays 0.
